// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 1;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready register slice; flush drops the held entry.
module fetch_out_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_instr_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0] out_pc_o
);

  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= load_instr_i;
      pc_q    <= load_pc_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_instr_o = instr_q;
  assign out_pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem reads,
// redirect squash, and a one-entry buffer towards decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

  logic              buf_free;
  logic              req_fire;
  logic              buf_load;
  logic [DATA_W-1:0] buf_instr;
  logic [ADDR_W-1:0] buf_pc;

  // Buffer can take a new entry if empty or being drained this cycle.
  assign buf_free       = !if_valid || if_ready;
  assign imem_req_valid = rst_n && (state_q == S_REQ) && buf_free;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    buf_load      = 1'b0;
    buf_instr     = hold_instr_q;
    buf_pc        = hold_pc_q;

    if (redir_valid) begin
      // Redirect wins; a request still owed by imem must be squashed.
      pc_d = redir_target;
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            inflight_pc_d = pc_q;
            kill_d        = 1'b1;
            state_d       = S_WAIT;
          end
        end
        S_WAIT: begin
          kill_d  = !imem_rsp_valid;
          state_d = imem_rsp_valid ? S_REQ : S_WAIT;
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + ADDR_W'(PC_STEP);
            state_d       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (buf_free) begin
              buf_load  = 1'b1;
              buf_instr = imem_rsp_data;
              buf_pc    = inflight_pc_q;
              state_d   = S_REQ;
            end else begin
              hold_instr_d = imem_rsp_data;
              hold_pc_d    = inflight_pc_q;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (buf_free) begin
            buf_load = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  fetch_out_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redir_valid),
    .load_i       (buf_load),
    .load_instr_i (buf_instr),
    .load_pc_i    (buf_pc),
    .out_ready_i  (if_ready),
    .out_valid_o  (if_valid),
    .out_instr_o  (if_instr),
    .out_pc_o     (if_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem responder model plus an expected-PC scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic        acc_ev = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  int          last_x = 0;
  int          prev_x = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] st_pc = 32'h0;
  logic [31:0] st_instr = 32'h0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redir_valid    (redir_valid),
    .redir_target   (redir_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // imem: one outstanding read, response 'lat' cycles after accept
  always @(posedge clk) begin : imem_model
    logic        acc;
    logic [31:0] a;
    cyc++;
    acc      = imem_req_valid && imem_req_ready;
    a        = imem_addr;
    acc_ev   = acc;
    acc_addr = a;
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      paddr = a;
      cnt   = lat;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(paddr);
      end
    end
  end

  // Decode-side monitor: scoreboard pops on transfer, stability while stalled
  always @(negedge clk) begin : if_monitor
    logic [31:0] exp;
    if (rst_n && stall_prev) begin
      check("hold_valid", 32'(if_valid), 32'd1);
      check("hold_pc", if_pc, st_pc);
      check("hold_instr", if_instr, st_instr);
    end
    stall_prev = rst_n && if_valid && !if_ready && !redir_valid;
    st_pc      = if_pc;
    st_instr   = if_instr;
    if (rst_n && if_valid && if_ready && !redir_valid) begin
      tests++;
      assert (sb_q.size() > 0) else begin
        fails++;
        $error("FAIL xfer_unexpected: observed pc %h expected none", if_pc);
      end
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check("xfer_pc", if_pc, exp);
        check("xfer_instr", if_instr, instr_of(exp));
      end
      prev_x = last_x;
      last_x = cyc;
    end
  end

  task automatic wait_size(input int n, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() <= n) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_drain", 32'(ok), 32'd1);
  endtask

  task automatic wait_acc(input logic [31:0] a, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (acc_ev && acc_addr == a) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("wait_accept", 32'(ok), 32'd1);
  endtask

  task automatic pulse_redir(input logic [31:0] tgt);
    redir_target = tgt;
    redir_valid  = 1'b1;
    @(posedge clk);
    #1;
    redir_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redir_valid    = 1'b0;
    redir_target   = 32'h0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);

    // Sequential fetch, 1-cycle imem, decode always ready
    for (int i = 0; i <= 12; i++) sb_q.push_back(32'(i));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_addr", imem_addr, 32'h0);
    check("first_req", 32'(imem_req_valid), 32'd1);
    wait_size(5, 200);
    if_ready = 1'b0;
    check("rate", 32'(last_x - prev_x), 32'd2);

    // Decode stall: no new request while buffer occupied
    repeat (6) begin
      @(negedge clk);
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    check("stall_pc", if_pc, 32'h8);
    @(posedge clk);
    #1 if_ready = 1'b1;

    // Redirect while waiting on imem
    lat = 3;
    sb_q.push_back(32'h40);
    sb_q.push_back(32'h41);
    sb_q.push_back(32'h42);
    wait_acc(32'd13, 200);
    lat = 2;
    pulse_redir(32'h40);
    @(negedge clk);
    check("redir_wait_addr", imem_addr, 32'h40);
    check("redir_wait_req", 32'(imem_req_valid), 32'd0);

    // Redirect coincident with imem response
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h101);
    wait_acc(32'h43, 200);
    @(posedge clk);
    #1;
    pulse_redir(32'h100);
    @(negedge clk);
    check("redir_rsp_addr", imem_addr, 32'h100);
    check("redir_rsp_req", 32'(imem_req_valid), 32'd1);

    // PC wrap at top of address space
    sb_q.push_back(32'hFFFF_FFFF);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h1);
    wait_acc(32'h102, 200);
    pulse_redir(32'hFFFF_FFFF);
    lat = 3;
    @(negedge clk);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    wait_size(0, 200);
    if_ready = 1'b0;

    // Reset while waiting; stale response afterwards is ignored
    wait_acc(32'h2, 50);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_if_valid", 32'(if_valid), 32'd0);
    check("midrst_if_instr", if_instr, 32'h0);
    check("midrst_if_pc", if_pc, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_addr", imem_addr, 32'h0);
    check("postrst_req", 32'(imem_req_valid), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("stale_ignored", 32'(if_valid), 32'd0);
    end
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h1);
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    wait_size(0, 200);
    if_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
